// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares the single write port (W0) and single read port (R0) of
//            the test-harness RAM between two requesters. Port 0 is the hex
//            preload client, port 1 the harness/core client. After reset only
//            port 0 is served until the preload finishes; afterwards a read
//            and a write may issue together, and same-kind conflicts are
//            settled by a 1-bit round-robin pointer. Read responses return
//            one cycle after the grant to the port that issued them.
// Ports    : clk, reset (async, active-high), preload_done
//            p0_*/p1_* : req_valid/ready/write/addr/wdata, rsp_valid/rdata
//            ram_W0_*  : en/addr/data/mask     ram_R0_* : en/addr/data
//            preload_busy, stall_cnt (saturating 16-bit stall counter)
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 128,
    parameter bit PRELOAD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              preload_done,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,

    output logic              ram_W0_en,
    output logic [ADDR_W-1:0] ram_W0_addr,
    output logic [DATA_W-1:0] ram_W0_data,
    output logic              ram_W0_mask,
    output logic              ram_R0_en,
    output logic [ADDR_W-1:0] ram_R0_addr,
    input  logic [DATA_W-1:0] ram_R0_data,

    output logic              preload_busy,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [0:0] {
        ST_PRELOAD = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    localparam state_t      C_RESET_STATE = PRELOAD_EN ? ST_PRELOAD : ST_RUN;
    localparam logic [15:0] C_STALL_MAX   = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rr;
    logic        r_rd_pending;
    logic        r_rd_sel;
    logic [15:0] r_stall_cnt;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_conflict;
    logic        w_wr0;
    logic        w_wr1;
    logic        w_rd0;
    logic        w_rd1;
    logic        w_stall_evt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_conflict  = 1'b0;

        case (r_state)
            ST_PRELOAD: begin
                // Port 1 waits; port 0 gets every command it presents,
                // including one presented in the cycle preload_done rises.
                w_gnt0 = p0_req_valid;
                if (preload_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A read and a write can issue together since they use
                // different RAM ports; only same-kind pairs collide.
                w_conflict = p0_req_valid & p1_req_valid &
                             (p0_req_write == p1_req_write);
                if (w_conflict) begin
                    w_gnt0 = ~r_rr;
                    w_gnt1 = r_rr;
                end else begin
                    w_gnt0 = p0_req_valid;
                    w_gnt1 = p1_req_valid;
                end
            end
            default: begin
                w_state_nxt = C_RESET_STATE;
            end
        endcase

        // Grants (and hence ready/en) must drop the moment reset rises,
        // not at the next clock edge.
        if (reset) begin
            w_gnt0     = 1'b0;
            w_gnt1     = 1'b0;
            w_conflict = 1'b0;
        end
    end

    assign p0_req_ready = w_gnt0;
    assign p1_req_ready = w_gnt1;
    assign preload_busy = (r_state == ST_PRELOAD);

    // ------------------------------------------------------------------
    // Issue path: at most one write and one read winner per cycle, so
    // each RAM port mux only needs to look at which port owns it.
    // ------------------------------------------------------------------
    assign w_wr0 = w_gnt0 &  p0_req_write;
    assign w_wr1 = w_gnt1 &  p1_req_write;
    assign w_rd0 = w_gnt0 & ~p0_req_write;
    assign w_rd1 = w_gnt1 & ~p1_req_write;

    assign ram_W0_en   = w_wr0 | w_wr1;
    assign ram_W0_addr = w_wr0 ? p0_req_addr  : p1_req_addr;
    assign ram_W0_data = w_wr0 ? p0_req_wdata : p1_req_wdata;
    assign ram_W0_mask = 1'b1;

    assign ram_R0_en   = w_rd0 | w_rd1;
    assign ram_R0_addr = w_rd0 ? p0_req_addr : p1_req_addr;

    // ------------------------------------------------------------------
    // Round-robin pointer: after a conflict it names the port that lost,
    // so that port wins the next conflict.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (w_conflict) begin
            r_rr <= ~r_rr;
        end
    end

    // ------------------------------------------------------------------
    // Response path: remember who issued the read; the RAM returns data
    // one cycle later and it is broadcast, only valid is steered. The
    // async clear drops any in-flight response on reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pending <= 1'b0;
            r_rd_sel     <= 1'b0;
        end else begin
            r_rd_pending <= ram_R0_en;
            r_rd_sel     <= w_rd1;
        end
    end

    assign p0_rsp_valid = r_rd_pending & ~r_rd_sel;
    assign p1_rsp_valid = r_rd_pending &  r_rd_sel;
    assign p0_rsp_rdata = ram_R0_data;
    assign p1_rsp_rdata = ram_R0_data;

    // ------------------------------------------------------------------
    // Stall counter: any presented command that is not taken this cycle.
    // ------------------------------------------------------------------
    assign w_stall_evt = (p0_req_valid & ~w_gnt0) | (p1_req_valid & ~w_gnt1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_evt && (r_stall_cnt != C_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
